// File: rtl/sqrt_iter_pkg.sv
// rtl/sqrt_iter_pkg.sv - shared types and helpers for the iterative square root
//
// Purpose: FSM state encoding, counter-width helper and the argument width
// check used by sqrt_iter_param and, later, the unrolled pipelined sqrt.
package sqrt_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Bit counter must be at least one bit wide even when it only counts to 0.
  function automatic int cnt_width(input int res_width);
    return (clog2(res_width) < 1) ? 1 : clog2(res_width);
  endfunction

  // The digit recurrence consumes two radicand bits per step.
  function automatic bit width_ok(input int data_width);
    return (data_width >= 4) && ((data_width % 2) == 0);
  endfunction

endpackage

// File: rtl/sqrt_iter_step.sv
// rtl/sqrt_iter_step.sv - one restoring digit of the integer square root
//
// Purpose: combinational single-digit step; brings down two radicand bits,
// tries subtracting {root,01} and appends the resulting root bit.
// Ports:
//   root_i  [RES_WIDTH-1:0]  partial root so far
//   rem_i   [RES_WIDTH+1:0]  partial remainder so far
//   bits_i  [1:0]            next two radicand bits, MSB first
//   root_o  [RES_WIDTH-1:0]  partial root after this digit
//   rem_o   [RES_WIDTH+1:0]  partial remainder after this digit
module sqrt_iter_step #(
  parameter int RES_WIDTH = 8
) (
  input  logic [RES_WIDTH-1:0] root_i,
  input  logic [RES_WIDTH+1:0] rem_i,
  input  logic [1:0]           bits_i,
  output logic [RES_WIDTH-1:0] root_o,
  output logic [RES_WIDTH+1:0] rem_o
);

  localparam int WW = RES_WIDTH + 4;

  logic [WW-1:0]        rem_sh;
  logic [WW-1:0]        trial;
  logic [WW-1:0]        diff;
  logic                 ge;
  logic [1:0]           unused_rem_hi;
  logic                 unused_root_msb;

  // Computed at full width; the remainder bound (rem <= 2*root) guarantees
  // the discarded upper bits are always zero.
  assign rem_sh = {rem_i, bits_i};
  assign trial  = {2'b00, root_i, 2'b01};
  assign ge     = (rem_sh >= trial);
  assign diff   = ge ? (rem_sh - trial) : rem_sh;

  assign {unused_rem_hi, rem_o}    = diff;
  assign {unused_root_msb, root_o} = {root_i, ge};

endmodule

// File: rtl/sqrt_iter_param.sv
// rtl/sqrt_iter_param.sv - multi-cycle integer square root, one root bit per clock
//
// Purpose: parametrised restoring square root with remainder output and
// optional round-to-nearest, valid/ready handshakes on both sides.
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous active-high reset
//   arg_vld  argument valid          arg_rdy  ready for an argument (IDLE)
//   arg      unsigned radicand       round    1 = round-to-nearest, 0 = floor
//   res_vld  result valid, held      res_rdy  consumer accepts result
//   res      square root             rem      floor remainder arg - floor_root^2
module sqrt_iter_param
  import sqrt_iter_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arg_vld,
  output logic                      arg_rdy,
  input  logic [DATA_WIDTH-1:0]     arg,
  input  logic                      round,
  output logic                      res_vld,
  input  logic                      res_rdy,
  output logic [DATA_WIDTH/2-1:0]   res,
  output logic [DATA_WIDTH/2:0]     rem
);

  localparam int RES_WIDTH = DATA_WIDTH / 2;
  localparam int CW        = cnt_width(RES_WIDTH);

  if (!width_ok(DATA_WIDTH)) begin : g_width_check
    $error("sqrt_iter_param: DATA_WIDTH must be even and >= 4");
  end

  state_t                 state_q, state_d;

  logic [DATA_WIDTH-1:0]  arg_q, arg_d;
  logic                   round_q, round_d;
  logic [RES_WIDTH-1:0]   root_q, root_d;
  logic [RES_WIDTH+1:0]   remp_q, remp_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [RES_WIDTH-1:0]   res_q, res_d;
  logic [RES_WIDTH:0]     rem_q, rem_d;

  logic [RES_WIDTH-1:0]   root_nx;
  logic [RES_WIDTH+1:0]   rem_nx;
  logic                   round_up;
  logic [RES_WIDTH-1:0]   root_final;

  sqrt_iter_step #(
    .RES_WIDTH (RES_WIDTH)
  ) u_step (
    .root_i (root_q),
    .rem_i  (remp_q),
    .bits_i (arg_q[DATA_WIDTH-1:DATA_WIDTH-2]),
    .root_o (root_nx),
    .rem_o  (rem_nx)
  );

  // Round up when the fractional part is >= 0.5, i.e. rem > root; an
  // all-ones root cannot be incremented and saturates instead.
  assign round_up   = round_q && (rem_nx > {2'b00, root_nx}) && !(&root_nx);
  assign root_final = round_up ? (root_nx + RES_WIDTH'(1)) : root_nx;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arg_vld)         state_d = CALC;
      CALC:    if (cnt_q == '0)     state_d = DONE;
      DONE:    if (res_rdy)         state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    arg_rdy = (state_q == IDLE);
    res_vld = (state_q == DONE);
  end

  // Datapath next-state
  always_comb begin
    arg_d   = arg_q;
    round_d = round_q;
    root_d  = root_q;
    remp_d  = remp_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (arg_vld) begin
          arg_d   = arg;
          round_d = round;
          root_d  = '0;
          remp_d  = '0;
          cnt_d   = CW'(RES_WIDTH - 1);
        end
      end
      CALC: begin
        arg_d  = {arg_q[DATA_WIDTH-3:0], 2'b00};
        root_d = root_nx;
        remp_d = rem_nx;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          res_d = root_final;
          rem_d = rem_nx[RES_WIDTH:0];
        end
      end
      default: ;
    endcase
  end

  // Working registers; always initialised on accept, so no reset needed.
  always_ff @(posedge clk) begin
    arg_q   <= arg_d;
    round_q <= round_d;
    root_q  <= root_d;
    remp_q  <= remp_d;
    cnt_q   <= cnt_d;
  end

  // Result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
      rem_q <= '0;
    end else begin
      res_q <= res_d;
      rem_q <= rem_d;
    end
  end

  assign res = res_q;
  assign rem = rem_q;

endmodule

// File: tb/tb_sqrt_iter_param.sv
// tb/tb_sqrt_iter_param.sv - directed and reference-model checks for sqrt_iter_param
module tb_sqrt_iter_param;

  localparam int DW = 16;
  localparam int RW = DW / 2;

  logic          clk;
  logic          rst;
  logic          arg_vld;
  logic          arg_rdy;
  logic [DW-1:0] arg;
  logic          round;
  logic          res_vld;
  logic          res_rdy;
  logic [RW-1:0] res;
  logic [RW:0]   rem;

  int n_tests;
  int n_fail;

  sqrt_iter_param #(
    .DATA_WIDTH (DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .arg_vld (arg_vld),
    .arg_rdy (arg_rdy),
    .arg     (arg),
    .round   (round),
    .res_vld (res_vld),
    .res_rdy (res_rdy),
    .res     (res),
    .rem     (rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: largest r with r*r <= a, found by linear search.
  task automatic ref_sqrt(input int unsigned a, input bit rnd,
                          output int unsigned r_out, output int unsigned m_out);
    int unsigned r;
    r = 0;
    while ((r + 1) * (r + 1) <= a) r++;
    m_out = a - r * r;
    r_out = (rnd && (m_out > r) && (r != (1 << RW) - 1)) ? r + 1 : r;
  endtask

  task automatic wait_rdy();
    for (int i = 0; i < 20 && !arg_rdy; i++) begin
      @(posedge clk); #1;
    end
    chk("arg_rdy_wait", arg_rdy, 1);
  endtask

  // One full transaction: accept, latency check, optional stall, release.
  task automatic do_op(input string tag, input logic [DW-1:0] a, input bit rnd,
                       input logic [RW-1:0] er, input logic [RW:0] em, input int stall);
    wait_rdy();
    arg = a; round = rnd; arg_vld = 1'b1;
    @(posedge clk); #1;
    arg_vld = 1'b0;
    chk({tag, "_busy"}, arg_rdy, 0);
    repeat (RW - 2) @(posedge clk);
    #0;
    @(posedge clk); #1;
    chk({tag, "_early"}, res_vld, 0);
    @(posedge clk); #1;
    chk({tag, "_vld"}, res_vld, 1);
    chk({tag, "_res"}, res, er);
    chk({tag, "_rem"}, rem, em);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_vld"}, res_vld, 1);
      chk({tag, "_hold_res"}, res, er);
    end
    res_rdy = 1'b1;
    @(posedge clk); #1;
    res_rdy = 1'b0;
    chk({tag, "_drop"}, res_vld, 0);
    chk({tag, "_idle"}, arg_rdy, 1);
  endtask

  initial begin
    int unsigned ra, rr, rm;
    bit          rb;
    int          seen;

    n_tests = 0; n_fail = 0;
    rst = 1'b1; arg_vld = 1'b0; arg = '0; round = 1'b0; res_rdy = 1'b0;
    #1;
    chk("rst_vld", res_vld, 0);
    chk("rst_res", res, 0);
    chk("rst_rem", rem, 0);
    chk("rst_rdy", arg_rdy, 1);
    #11 rst = 1'b0;
    @(posedge clk); #1;

    do_op("zero",    16'd0,     1'b0, 8'd0,   9'd0,   0);
    do_op("max_fl",  16'd65535, 1'b0, 8'd255, 9'd510, 1);
    do_op("max_rn",  16'd65535, 1'b1, 8'd255, 9'd510, 0);
    do_op("a20_rn",  16'd20,    1'b1, 8'd4,   9'd4,   0);
    do_op("a21_rn",  16'd21,    1'b1, 8'd5,   9'd5,   2);
    do_op("a21_fl",  16'd21,    1'b0, 8'd4,   9'd5,   0);

    // Back-pressure with a competing argument presented during the stall.
    wait_rdy();
    arg = 16'd144; round = 1'b0; arg_vld = 1'b1;
    @(posedge clk); #1;
    arg_vld = 1'b0;
    repeat (RW) @(posedge clk);
    #1;
    chk("bp_vld", res_vld, 1);
    chk("bp_res", res, 12);
    chk("bp_rem", rem, 0);
    arg = 16'd50; arg_vld = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_vld", res_vld, 1);
      chk("bp_hold_res", res, 12);
      chk("bp_hold_rem", rem, 0);
      chk("bp_no_accept", arg_rdy, 0);
    end
    res_rdy = 1'b1;
    @(posedge clk); #1;
    res_rdy = 1'b0;
    chk("bp_release_vld", res_vld, 0);
    chk("bp_release_rdy", arg_rdy, 1);
    @(posedge clk); #1;
    arg_vld = 1'b0;
    chk("bp_new_accept", arg_rdy, 0);
    repeat (RW) @(posedge clk);
    #1;
    chk("bp_new_vld", res_vld, 1);
    chk("bp_new_res", res, 7);
    chk("bp_new_rem", rem, 1);
    res_rdy = 1'b1;
    @(posedge clk); #1;
    res_rdy = 1'b0;

    // Reset in the middle of CALC.
    wait_rdy();
    arg = 16'd1000; round = 1'b0; arg_vld = 1'b1;
    @(posedge clk); #1;
    arg_vld = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_vld", res_vld, 0);
    chk("abort_res", res, 0);
    chk("abort_rem", rem, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (res_vld) seen++;
    end
    chk("abort_no_vld", seen, 0);
    do_op("a1000", 16'd1000, 1'b0, 8'd31, 9'd39, 0);

    // Reference-model sweep with random stalls.
    for (int k = 0; k < 16; k++) begin
      ra = $urandom_range(0, 65535);
      rb = 1'($urandom_range(0, 1));
      ref_sqrt(ra, rb, rr, rm);
      do_op("sweep", DW'(ra), rb, RW'(rr), (RW + 1)'(rm), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
